// File: rtl/tetris_pkg.sv
// Shared playfield geometry, controller states and move encoding for the
// falling-piece sequencer.
package tetris_pkg;

  localparam int unsigned BOARD_W = 10;
  localparam int unsigned BOARD_H = 20;
  localparam int unsigned SPAWN_X = 4;
  localparam int unsigned X_W     = 4;
  localparam int unsigned Y_W     = 5;

  typedef enum logic [2:0] {
    SPAWN,
    SPAWN_QRY,
    FALLING,
    QUERY,
    LOCK,
    WAIT_BOARD,
    GAME_OVER
  } state_e;

  typedef enum logic [1:0] {
    MV_LEFT,
    MV_RIGHT,
    MV_DOWN
  } move_e;

endpackage

// File: rtl/gravity_timer.sv
// Wrap counter for the gravity cadence: counts while enabled, pulses tick_c
// on the wrap cycle; clr zeroes it and masks the tick.
module gravity_timer #(
  parameter int unsigned TICKS = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_c = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        tick_c = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piece_fall_ctrl.sv
// Active-piece sequencer: spawns, moves and locks the falling piece, arbitrating
// player moves against gravity through board collision queries.
module piece_fall_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned GRAVITY_TICKS = 25000000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_left,
  input  logic           i_right,
  input  logic           i_down,
  input  logic           i_board_busy,
  input  logic           i_qry_done,
  input  logic           i_qry_occupied,
  output logic           o_qry_valid,
  output logic [X_W-1:0] o_qry_x,
  output logic [Y_W-1:0] o_qry_y,
  output logic           o_lock_we,
  output logic [X_W-1:0] o_lock_x,
  output logic [Y_W-1:0] o_lock_y,
  output logic [X_W-1:0] o_x_pos,
  output logic [Y_W-1:0] o_y_pos,
  output logic           o_piece_active,
  output logic           o_game_over
);

  state_e           state_q, state_d;
  move_e            mv_q, mv_d;
  logic [X_W-1:0]   x_q, x_d, qx_q, qx_d, lx_q, lx_d;
  logic [Y_W-1:0]   y_q, y_d, qy_q, qy_d, ly_q, ly_d;
  logic             active_q, active_d, qv_q, qv_d, lwe_q, lwe_d;
  logic             go_q, go_d, pend_q, pend_d;
  logic             tmr_en, tmr_clr, grav_tick_c;

  assign tmr_en = (state_q == FALLING) || (state_q == QUERY);

  gravity_timer #(.TICKS(GRAVITY_TICKS)) u_gravity (
    .clk    (clk),
    .rst    (rst),
    .en     (tmr_en),
    .clr    (tmr_clr),
    .tick_c (grav_tick_c)
  );

  always_comb begin
    state_d  = state_q;
    mv_d     = mv_q;
    x_d      = x_q;
    y_d      = y_q;
    qx_d     = qx_q;
    qy_d     = qy_q;
    lx_d     = lx_q;
    ly_d     = ly_q;
    active_d = active_q;
    qv_d     = qv_q;
    lwe_d    = 1'b0;
    go_d     = go_q;
    pend_d   = pend_q | grav_tick_c;
    tmr_clr  = 1'b0;

    case (state_q)
      SPAWN: begin
        if (!i_board_busy) begin
          qv_d    = 1'b1;
          qx_d    = X_W'(SPAWN_X);
          qy_d    = '0;
          state_d = SPAWN_QRY;
        end
      end

      SPAWN_QRY: begin
        if (i_qry_done) begin
          qv_d = 1'b0;
          if (i_qry_occupied) begin
            go_d     = 1'b1;
            active_d = 1'b0;
            state_d  = GAME_OVER;
          end else begin
            x_d      = X_W'(SPAWN_X);
            y_d      = '0;
            active_d = 1'b1;
            tmr_clr  = 1'b1;
            state_d  = FALLING;
          end
        end
      end

      FALLING: begin
        // Down beats left beats right; opposing lateral requests cancel.
        if (pend_q || i_down) begin
          pend_d = grav_tick_c;
          if (i_down) tmr_clr = 1'b1;
          if (y_q == Y_W'(BOARD_H - 1)) begin
            lwe_d    = 1'b1;
            lx_d     = x_q;
            ly_d     = y_q;
            active_d = 1'b0;
            state_d  = LOCK;
          end else begin
            qv_d    = 1'b1;
            qx_d    = x_q;
            qy_d    = y_q + Y_W'(1);
            mv_d    = MV_DOWN;
            state_d = QUERY;
          end
        end else if (i_left && !i_right) begin
          if (x_q != '0) begin
            qv_d    = 1'b1;
            qx_d    = x_q - X_W'(1);
            qy_d    = y_q;
            mv_d    = MV_LEFT;
            state_d = QUERY;
          end
        end else if (i_right && !i_left) begin
          if (x_q != X_W'(BOARD_W - 1)) begin
            qv_d    = 1'b1;
            qx_d    = x_q + X_W'(1);
            qy_d    = y_q;
            mv_d    = MV_RIGHT;
            state_d = QUERY;
          end
        end
      end

      QUERY: begin
        if (i_qry_done) begin
          qv_d = 1'b0;
          if (!i_qry_occupied) begin
            x_d     = qx_q;
            y_d     = qy_q;
            state_d = FALLING;
          end else if (mv_q == MV_DOWN) begin
            lwe_d    = 1'b1;
            lx_d     = x_q;
            ly_d     = y_q;
            active_d = 1'b0;
            state_d  = LOCK;
          end else begin
            state_d = FALLING;
          end
        end
      end

      LOCK:       state_d = WAIT_BOARD;

      WAIT_BOARD: if (!i_board_busy) state_d = SPAWN;

      GAME_OVER:  state_d = GAME_OVER;

      default:    state_d = SPAWN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SPAWN;
      mv_q     <= MV_DOWN;
      x_q      <= '0;
      y_q      <= '0;
      qx_q     <= '0;
      qy_q     <= '0;
      lx_q     <= '0;
      ly_q     <= '0;
      active_q <= 1'b0;
      qv_q     <= 1'b0;
      lwe_q    <= 1'b0;
      go_q     <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mv_q     <= mv_d;
      x_q      <= x_d;
      y_q      <= y_d;
      qx_q     <= qx_d;
      qy_q     <= qy_d;
      lx_q     <= lx_d;
      ly_q     <= ly_d;
      active_q <= active_d;
      qv_q     <= qv_d;
      lwe_q    <= lwe_d;
      go_q     <= go_d;
      pend_q   <= pend_d;
    end
  end

  assign o_qry_valid    = qv_q;
  assign o_qry_x        = qx_q;
  assign o_qry_y        = qy_q;
  assign o_lock_we      = lwe_q;
  assign o_lock_x       = lx_q;
  assign o_lock_y       = ly_q;
  assign o_x_pos        = x_q;
  assign o_y_pos        = y_q;
  assign o_piece_active = active_q;
  assign o_game_over    = go_q;

endmodule

// File: tb/tb_piece_fall_ctrl.sv
// Directed bench for piece_fall_ctrl with a 4-cycle gravity period and a small
// board model answering collision queries.
module tb_piece_fall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_left = 1'b0, i_right = 1'b0, i_down = 1'b0, i_board_busy = 1'b0;
  logic       i_qry_done = 1'b0, i_qry_occupied = 1'b0;
  logic       o_qry_valid, o_lock_we, o_piece_active, o_game_over;
  logic [3:0] o_qry_x, o_lock_x, o_x_pos;
  logic [4:0] o_qry_y, o_lock_y, o_y_pos;

  int passed = 0;
  int total  = 0;
  logic resp_en = 1'b1;
  logic occ [10][20];

  typedef struct {
    logic l, r, d;
    logic exp_qv;
    int   exp_qx, exp_qy, exp_x, exp_y;
  } vec_t;
  vec_t vecs [18];

  piece_fall_ctrl #(.GRAVITY_TICKS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_left         (i_left),
    .i_right        (i_right),
    .i_down         (i_down),
    .i_board_busy   (i_board_busy),
    .i_qry_done     (i_qry_done),
    .i_qry_occupied (i_qry_occupied),
    .o_qry_valid    (o_qry_valid),
    .o_qry_x        (o_qry_x),
    .o_qry_y        (o_qry_y),
    .o_lock_we      (o_lock_we),
    .o_lock_x       (o_lock_x),
    .o_lock_y       (o_lock_y),
    .o_x_pos        (o_x_pos),
    .o_y_pos        (o_y_pos),
    .o_piece_active (o_piece_active),
    .o_game_over    (o_game_over)
  );

  always #5 clk = ~clk;

  // Board model: answers any outstanding query on the next edge.
  always @(negedge clk) begin
    if (resp_en && o_qry_valid) begin
      i_qry_done     = 1'b1;
      i_qry_occupied = occ[o_qry_x][o_qry_y];
    end else begin
      i_qry_done     = 1'b0;
      i_qry_occupied = 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic logic cond(input int sel);
    case (sel)
      0:       return o_lock_we;
      1:       return o_piece_active;
      2:       return o_game_over;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_cond(input int sel, input string nm);
    int n = 0;
    while (!cond(sel) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(nm, 32'(cond(sel)), 32'd1);
  endtask

  task automatic wait_row();
    logic [4:0] y0;
    int n;
    y0 = o_y_pos;
    n  = 0;
    while (o_y_pos == y0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("row_step", 32'(o_y_pos != y0), 32'd1);
  endtask

  task automatic check_lock(input string nm, input int x, input int y);
    wait_cond(0, {nm, "_wait"});
    check({nm, "_x"}, 32'(o_lock_x), 32'(x));
    check({nm, "_y"}, 32'(o_lock_y), 32'(y));
    check({nm, "_inactive"}, 32'(o_piece_active), 32'd0);
  endtask

  task automatic check_spawn(input string nm);
    wait_cond(1, {nm, "_wait"});
    check({nm, "_x"}, 32'(o_x_pos), 32'd4);
    check({nm, "_y"}, 32'(o_y_pos), 32'd0);
    check({nm, "_go"}, 32'(o_game_over), 32'd0);
  endtask

  initial begin
    int busy_q;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 20; j++) occ[i][j] = 1'b0;

    // Wall / drop walk for the first piece: row y = index+1, last vector at y=19.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3, 1, 3, 1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2, 2, 2, 2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 3, 1, 3};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 4, 0, 4};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 5};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1, 6, 1, 6};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 2, 7, 2, 7};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3, 8, 3, 8};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4, 9, 4, 9};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5, 10, 5, 10};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 6, 11, 6, 11};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 7, 12, 7, 12};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8, 13, 8, 13};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 9, 14, 9, 14};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 9, 15};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 9, 16};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 9, 18, 9, 18};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 9, 19};

    repeat (2) @(negedge clk);
    check("rst_x", 32'(o_x_pos), 32'd0);
    check("rst_y", 32'(o_y_pos), 32'd0);
    check("rst_active", 32'(o_piece_active), 32'd0);
    check("rst_qv", 32'(o_qry_valid), 32'd0);
    check("rst_lwe", 32'(o_lock_we), 32'd0);
    check("rst_go", 32'(o_game_over), 32'd0);
    rst = 1'b0;

    check_spawn("spawn1");

    for (int i = 0; i < 18; i++) begin
      wait_row();
      i_left  = vecs[i].l;
      i_right = vecs[i].r;
      i_down  = vecs[i].d;
      @(negedge clk);
      i_left = 1'b0; i_right = 1'b0; i_down = 1'b0;
      check($sformatf("v%0d_qv", i), 32'(o_qry_valid), 32'(vecs[i].exp_qv));
      if (vecs[i].exp_qv) begin
        check($sformatf("v%0d_qx", i), 32'(o_qry_x), 32'(vecs[i].exp_qx));
        check($sformatf("v%0d_qy", i), 32'(o_qry_y), 32'(vecs[i].exp_qy));
      end
      @(negedge clk);
      check($sformatf("v%0d_x", i), 32'(o_x_pos), 32'(vecs[i].exp_x));
      check($sformatf("v%0d_y", i), 32'(o_y_pos), 32'(vecs[i].exp_y));
    end

    // Bottom lock, then board busy for 10 cycles holds off the respawn.
    check_lock("lock_bottom", 9, 19);
    occ[9][19] = 1'b1;
    @(negedge clk);
    check("lock_one_cycle", 32'(o_lock_we), 32'd0);
    i_board_busy = 1'b1;
    busy_q = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_qry_valid) busy_q++;
    end
    check("no_spawn_while_busy", 32'(busy_q), 32'd0);
    i_board_busy = 1'b0;
    check_spawn("spawn2");

    // Blocked lateral move, then gravity beats a simultaneous left.
    for (int j = 0; j < 20; j++) occ[5][j] = 1'b1;
    occ[4][3] = 1'b1;
    wait_row();
    i_right = 1'b1;
    @(negedge clk);
    i_right = 1'b0;
    check("blk_qv", 32'(o_qry_valid), 32'd1);
    check("blk_qx", 32'(o_qry_x), 32'd5);
    check("blk_qy", 32'(o_qry_y), 32'd1);
    @(negedge clk);
    check("blk_x", 32'(o_x_pos), 32'd4);
    check("blk_y", 32'(o_y_pos), 32'd1);
    wait_row();
    repeat (2) @(negedge clk);
    i_left = 1'b1;
    @(negedge clk);
    i_left = 1'b0;
    check("grav_left_qv", 32'(o_qry_valid), 32'd1);
    check("grav_left_qx", 32'(o_qry_x), 32'd4);
    check("grav_left_qy", 32'(o_qry_y), 32'd3);
    check_lock("lock_stack0", 4, 2);
    occ[4][2] = 1'b1;
    check_spawn("spawn3");
    check_lock("lock_stack1", 4, 1);
    occ[4][1] = 1'b1;
    check_spawn("spawn4");
    check_lock("lock_stack2", 4, 0);
    occ[4][0] = 1'b1;

    wait_cond(2, "game_over_wait");
    check("go_inactive", 32'(o_piece_active), 32'd0);
    repeat (20) @(negedge clk);
    check("go_sticky", 32'(o_game_over), 32'd1);
    check("go_no_query", 32'(o_qry_valid), 32'd0);

    // Restart, hold a lateral query open, then reset in the middle of it.
    rst = 1'b1;
    #1;
    check("rst_clears_go", 32'(o_game_over), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 20; j++) occ[i][j] = 1'b0;
    rst = 1'b0;
    check_spawn("spawn5");
    resp_en = 1'b0;
    i_left  = 1'b1;
    @(negedge clk);
    i_left = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_qv", 32'(o_qry_valid), 32'd1);
    check("hold_qx", 32'(o_qry_x), 32'd3);
    check("hold_qy", 32'(o_qry_y), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_qv", 32'(o_qry_valid), 32'd0);
    check("mid_rst_qx", 32'(o_qry_x), 32'd0);
    check("mid_rst_x", 32'(o_x_pos), 32'd0);
    check("mid_rst_y", 32'(o_y_pos), 32'd0);
    check("mid_rst_active", 32'(o_piece_active), 32'd0);
    check("mid_rst_lwe", 32'(o_lock_we), 32'd0);
    resp_en = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/piece_fall_ctrl.md
Name: piece_fall_ctrl

Overview:
- Sequences the single active falling piece on the 10x20 playfield.
- Owns the piece position registers (x 0..9, y 0..19) and the gravity timer.
- Arbitrates player move requests against gravity and issues collision queries and lock writes to the board store.
- Sits between the input debouncers and the board/VGA renderer; its x/y/active outputs drive the renderer directly.

Parameters:
- BOARD_W, 10: playfield columns; x range 0..BOARD_W-1.
- BOARD_H, 20: playfield rows; y range 0..BOARD_H-1, row 0 is the top.
- SPAWN_X, 4: spawn column; spawn row is always 0.
- GRAVITY_TICKS, 25000000: clk cycles per gravity step (0.5 s at 50 MHz).
- X_W, 4: x position width.
- Y_W, 5: y position width.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- i_left  in  1  single-cycle move-left request.
- i_right  in  1  single-cycle move-right request.
- i_down  in  1  single-cycle soft-drop request.
- i_board_busy  in  1  board is clearing rows; do not spawn.
- i_qry_done  in  1  board answers the current query (one-cycle pulse).
- i_qry_occupied  in  1  target cell is occupied; valid only with i_qry_done.
- o_qry_valid  out  1  collision query outstanding.
- o_qry_x  out  X_W  query column.
- o_qry_y  out  Y_W  query row.
- o_lock_we  out  1  one-cycle write of the piece into the board.
- o_lock_x  out  X_W  lock column.
- o_lock_y  out  Y_W  lock row.
- o_x_pos  out  X_W  current piece column.
- o_y_pos  out  Y_W  current piece row.
- o_piece_active  out  1  piece is visible and falling.
- o_game_over  out  1  sticky game-over flag.

Behaviour:
- Reset (async, immediate): state=SPAWN. o_x_pos=0, o_y_pos=0. o_piece_active, o_qry_valid, o_lock_we and o_game_over are 0. Gravity counter=0, pending_grav=0. Query and lock addresses are 0.
- States: SPAWN, SPAWN_QRY, FALLING, QUERY, LOCK, WAIT_BOARD, GAME_OVER.
- SPAWN:
  - If i_board_busy, stay.
  - Else drive query at (SPAWN_X,0) and go to SPAWN_QRY.
- SPAWN_QRY:
  - Hold o_qry_valid and address until i_qry_done.
  - If not occupied: x=SPAWN_X, y=0, piece_active=1, counter=0, go to FALLING.
  - If occupied: go to GAME_OVER.
- FALLING, event selection: the counter increments every cycle. At GRAVITY_TICKS-1 it wraps to 0 and sets pending_grav. Priority order:
  - Down (pending_grav or i_down).
  - Left.
  - Right.
  - i_left and i_right together with no down event: both ignored.
- FALLING, boundary rules (no query issued):
  - Left at x=0: rejected, stay in FALLING.
  - Right at x=BOARD_W-1: rejected.
  - Down at y=BOARD_H-1: go to LOCK.
- FALLING, otherwise: drive the query at the candidate cell (x±1, or y+1) and go to QUERY. Clear pending_grav when the down event is taken. An accepted i_down also zeroes the counter.
- QUERY:
  - o_qry_valid held high with a stable address until i_qry_done.
  - Free cell: commit the candidate position in the next cycle, return to FALLING.
  - Occupied on a lateral move: discard, return to FALLING.
  - Occupied on a down move: go to LOCK.
- Events while not in FALLING:
  - Player pulses are dropped.
  - A gravity wrap still sets pending_grav, so gravity is never lost.
  - The counter runs only in FALLING and QUERY.
- LOCK: o_lock_we=1 for exactly one cycle at the current x,y. piece_active=0 in the same cycle. Go to WAIT_BOARD.
- WAIT_BOARD:
  - Wait at least one cycle.
  - Leave when i_board_busy=0, then go to SPAWN.
  - The board raises busy on the cycle after lock_we if it is clearing.
- GAME_OVER: o_game_over=1 and piece_active=0. Stays here until rst.
- Latency:
  - Event seen in FALLING at cycle T gives o_qry_valid at T+1.
  - i_qry_done at cycle N gives the updated o_x_pos/o_y_pos at N+1.
- All outputs are registered.
- Position arithmetic uses unsigned X_W/Y_W values. Bounds are checked before ±1, so no wrap-around is possible.

Decomposition:
- tetris_pkg holds:
  - BOARD_W, BOARD_H, SPAWN_X.
  - X_W, Y_W.
  - The state enum.
  - The move-kind encoding (MV_LEFT, MV_RIGHT, MV_DOWN).
- One natural sub-module, gravity_timer: parameterised wrap counter with an enable input and a tick output.

Test Plan:
- Spawn: set GRAVITY_TICKS=4, release rst, board answers free -> o_piece_active=1, x=4, y=0, game_over=0.
- Gravity fall on an empty board: piece steps y 0→19, one row per ~4+query cycles. At y=19 the next tick gives o_lock_we with (4,19), then piece_active=0, then a respawn at (4,0).
- Walls: 4 i_left pulses -> x=0. A 5th i_left issues no o_qry_valid and x stays 0. Similarly, right to x=9 then a rejected extra pulse.
- Collision: board reports (5,y) occupied, i_right -> x unchanged. Board reports the cell below occupied on gravity -> lock at the current cell, then respawn.
- Simultaneous: i_left and i_right in the same cycle -> no query. i_left in the same cycle as a gravity tick -> down query is issued, left is dropped.
- Board busy, game over, reset mid-query:
  - i_board_busy held 10 cycles after a lock -> no spawn query until busy falls.
  - Spawn cell occupied -> o_game_over=1 and sticky.
  - rst asserted mid-QUERY -> all outputs return to reset values immediately.
